// File: rtl/axi4lite_counter_slave.sv
// AXI4-Lite slave exposing a 32-bit up/down counter (CTRL, LIMIT, COUNT, STATUS); optional irq via COUNTER_IRQ_EN.
// Latency: write commits one edge after both AW and W are latched; read data is registered on the AR handshake edge.
// Backpressure: BVALID/RVALID hold until BREADY/RREADY; no new AW/W while BVALID, no new AR while RVALID.
module axi4lite_counter_slave #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 4,
    parameter logic [31:0] LIMIT_RESET        = 32'hFFFF_FFFF
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    input  logic                              cnt_tick,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     count
`ifdef COUNTER_IRQ_EN
    ,
    output logic                              irq
`endif
);

    typedef enum logic [1:0] {WR_COLLECT, WR_COMMIT, WR_RESP} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_READY, RD_DATA} rd_state_t;

    wr_state_t   r_wr_state, w_wr_next;
    rd_state_t   r_rd_state, w_rd_next;

    logic        r_awready, r_wready;
    logic        r_aw_full, r_w_full;
    logic [1:0]  r_awaddr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_rdata;

    logic        r_en, r_up, r_wrap;
    logic [31:0] r_limit, r_count;

    logic        w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic        w_wr_ctrl, w_wr_limit, w_wr_count, w_wr_status;
    logic        w_clr, w_step, w_wrap_evt, w_wrap_clr, w_wrap_nxt;
    logic [31:0] w_count_nxt, w_rd_mux;
    logic        w_mask_rd;

    // Address LSBs and protection bits carry no meaning for this register file.
    logic        w_unused_ok;
    assign w_unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    function automatic logic [31:0] f_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                            input logic [3:0] strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    assign w_aw_hs     = r_awready & S_AXI_AWVALID;
    assign w_w_hs      = r_wready & S_AXI_WVALID;
    assign w_ar_hs     = (r_rd_state == RD_READY) & S_AXI_ARVALID;
    assign w_commit    = (r_wr_state == WR_COMMIT);
    assign w_wr_ctrl   = w_commit && (r_awaddr == 2'd0);
    assign w_wr_limit  = w_commit && (r_awaddr == 2'd1);
    assign w_wr_count  = w_commit && (r_awaddr == 2'd2);
    assign w_wr_status = w_commit && (r_awaddr == 2'd3);
    assign w_clr       = w_wr_ctrl & r_wstrb[0] & r_wdata[2];
    assign w_step      = r_en & cnt_tick;
    assign w_wrap_clr  = w_wr_status & r_wstrb[0] & r_wdata[0];
    // A wrap on the same edge as a write-1-to-clear keeps WRAP set.
    assign w_wrap_nxt  = w_wrap_evt | (r_wrap & ~w_wrap_clr);

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = (r_wr_state == WR_RESP);
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = (r_rd_state == RD_READY);
    assign S_AXI_RVALID  = (r_rd_state == RD_DATA);
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RDATA   = r_rdata;
    assign count         = r_count;

    // Write FSM state register.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) r_wr_state <= WR_COLLECT;
        else          r_wr_state <= w_wr_next;
    end

    // Write FSM next state: collect AW and W, commit once, then hold the response.
    always_comb begin
        w_wr_next = r_wr_state;
        case (r_wr_state)
            WR_COLLECT: if ((r_aw_full | w_aw_hs) && (r_w_full | w_w_hs)) w_wr_next = WR_COMMIT;
            WR_COMMIT:  w_wr_next = WR_RESP;
            WR_RESP:    if (S_AXI_BREADY) w_wr_next = WR_COLLECT;
            default:    w_wr_next = WR_COLLECT;
        endcase
    end

    // AW/W ready pulses and the address/data latches; both channels are independent.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_awaddr  <= 2'd0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
        end else begin
            r_awready <= (r_wr_state == WR_COLLECT) && S_AXI_AWVALID && !r_aw_full && !r_awready;
            r_wready  <= (r_wr_state == WR_COLLECT) && S_AXI_WVALID && !r_w_full && !r_wready;
            if (w_aw_hs) begin
                r_aw_full <= 1'b1;
                r_awaddr  <= S_AXI_AWADDR[3:2];
            end else if (w_commit) begin
                r_aw_full <= 1'b0;
            end
            if (w_w_hs) begin
                r_w_full <= 1'b1;
                r_wdata  <= S_AXI_WDATA;
                r_wstrb  <= S_AXI_WSTRB;
            end else if (w_commit) begin
                r_w_full <= 1'b0;
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) r_rd_state <= RD_IDLE;
        else          r_rd_state <= w_rd_next;
    end

    // Read FSM next state: ready pulse, then hold data until accepted.
    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            RD_IDLE:  if (S_AXI_ARVALID) w_rd_next = RD_READY;
            RD_READY: w_rd_next = S_AXI_ARVALID ? RD_DATA : RD_IDLE;
            RD_DATA:  if (S_AXI_RREADY) w_rd_next = RD_IDLE;
            default:  w_rd_next = RD_IDLE;
        endcase
    end

    // Register read mux; CLR is never stored so it reads 0.
    always_comb begin
        w_rd_mux = 32'd0;
        case (S_AXI_ARADDR[3:2])
            2'd0:    w_rd_mux = {28'd0, w_mask_rd, 1'b0, r_up, r_en};
            2'd1:    w_rd_mux = r_limit;
            2'd2:    w_rd_mux = r_count;
            default: w_rd_mux = {31'd0, r_wrap};
        endcase
    end

    // Capture read data on the AR handshake edge so COUNT reflects that cycle.
    always_ff @(posedge ACLK) begin
        if (!ARESETN)     r_rdata <= 32'd0;
        else if (w_ar_hs) r_rdata <= w_rd_mux;
    end

    // Counter next value: a COUNT write beats CLR's neighbour step, CLR beats a step.
    always_comb begin
        w_count_nxt = r_count;
        w_wrap_evt  = 1'b0;
        if (w_wr_count) begin
            w_count_nxt = f_merge(r_count, r_wdata, r_wstrb);
        end else if (w_clr) begin
            w_count_nxt = 32'd0;
        end else if (w_step) begin
            if (r_up) begin
                if (r_count >= r_limit) begin
                    w_count_nxt = 32'd0;
                    w_wrap_evt  = 1'b1;
                end else begin
                    w_count_nxt = r_count + 32'd1;
                end
            end else begin
                if (r_count == 32'd0) begin
                    w_count_nxt = r_limit;
                    w_wrap_evt  = 1'b1;
                end else begin
                    w_count_nxt = r_count - 32'd1;
                end
            end
        end
    end

    // Software-visible registers and the counter itself.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_en    <= 1'b0;
            r_up    <= 1'b0;
            r_limit <= LIMIT_RESET;
            r_count <= 32'd0;
            r_wrap  <= 1'b0;
        end else begin
            if (w_wr_ctrl && r_wstrb[0]) begin
                r_en <= r_wdata[0];
                r_up <= r_wdata[1];
            end
            if (w_wr_limit) r_limit <= f_merge(r_limit, r_wdata, r_wstrb);
            r_count <= w_count_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

`ifdef COUNTER_IRQ_EN
    logic r_mask, r_irq, w_mask_nxt;
    assign w_mask_nxt = (w_wr_ctrl && r_wstrb[0]) ? r_wdata[3] : r_mask;
    assign w_mask_rd  = r_mask;
    assign irq        = r_irq;

    // Interrupt mask and registered irq; irq follows WRAP on the same edge it changes.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_mask <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
            r_mask <= w_mask_nxt;
            r_irq  <= w_wrap_nxt & w_mask_nxt;
        end
    end
`else
    assign w_mask_rd = 1'b0;
`endif

endmodule
